vga_ctrl_param: RTL and testbench



---
 rtl/vga_ctrl_pkg.sv | 22 ++
 rtl/vga_ctrl_param_sync.sv | 94 +++++++++
 rtl/vga_ctrl_param.sv | 161 ++++++++++++++++
 tb/tb_vga_ctrl_param.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared constants for the parametrised VGA colour controller: channel-select
// codes and the default 640x480@60 timing. Optional feature macro: VGA_COLOR_BARS_EN.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_R   = 2'd0,
    SEL_G   = 2'd1,
    SEL_B   = 2'd2,
    SEL_ALL = 2'd3
  } sel_e;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_ctrl_param_sync.sv
// vga_sync_gen: pixel-tick divider, h/v counters and registered sync/visible/frame-start.
// With VGA_COLOR_BARS_EN defined it also exports the colour-bar index of the current pixel.
module vga_sync_gen
  import vga_ctrl_pkg::*;
#(
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_COLOR_BARS_EN
  output logic [2:0] bar,
`endif
  output logic       active,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          hs_on;
  logic          vs_on;

  assign tick   = (int'(div) == CLK_DIV - 1);
  assign h_last = (int'(h) == H_TOTAL - 1);
  assign v_last = (int'(v) == V_TOTAL - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end
      end
    end
  end

  assign hs_on      = (int'(h) >= HS_START) && (int'(h) < HS_END);
  assign vs_on      = (int'(v) >= VS_START) && (int'(v) < VS_END);
  assign active     = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign frame_tick = tick && (h == '0) && (v == '0);

`ifdef VGA_COLOR_BARS_EN
  assign bar = 3'((int'(h) * 8) / H_ACTIVE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      visible     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      visible     <= active;
      frame_start <= frame_tick;
    end
  end

endmodule

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA solid-colour controller: button-stepped saturating colour channels,
// double-buffered at frame start. Optional macro VGA_COLOR_BARS_EN adds the Barras input.
module vga_ctrl_param
  import vga_ctrl_pkg::*;
#(
  parameter int             CLK_DIV  = VGA_CLK_DIV,
  parameter int             H_ACTIVE = VGA_H_ACTIVE,
  parameter int             H_FP     = VGA_H_FP,
  parameter int             H_SYNC   = VGA_H_SYNC,
  parameter int             H_BP     = VGA_H_BP,
  parameter int             V_ACTIVE = VGA_V_ACTIVE,
  parameter int             V_FP     = VGA_V_FP,
  parameter int             V_SYNC   = VGA_V_SYNC,
  parameter int             V_BP     = VGA_V_BP,
  parameter logic           SYNC_POL = 1'b0,
  parameter int             R_W      = 3,
  parameter int             G_W      = 3,
  parameter int             B_W      = 2,
  parameter logic [R_W-1:0] R_INIT   = '1,
  parameter logic [G_W-1:0] G_INIT   = '1,
  parameter logic [B_W-1:0] B_INIT   = '1
) (
  input  logic           Clock,
  input  logic           reset,
  input  logic           Up,
  input  logic           Down,
  input  logic [1:0]     Sel,
`ifdef VGA_COLOR_BARS_EN
  input  logic           Barras,
`endif
  output logic [R_W-1:0] Rojo,
  output logic [G_W-1:0] Verde,
  output logic [B_W-1:0] Azul,
  output logic           Hsinc,
  output logic           Vsinc,
  output logic           Visible,
  output logic           FrameStart
);

  sel_e           sel;
  logic           up_q, up_d, down_q, down_d;
  logic           inc, dec;
  logic           hit_r, hit_g, hit_b;
  logic           active, frame_tick;
  logic [R_W-1:0] r_work, r_next, r_disp, r_pix;
  logic [G_W-1:0] g_work, g_next, g_disp, g_pix;
  logic [B_W-1:0] b_work, b_next, b_disp, b_pix;
`ifdef VGA_COLOR_BARS_EN
  logic [2:0]     bar;
`endif

  vga_sync_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_sync (
`ifdef VGA_COLOR_BARS_EN
    .bar        (bar),
`endif
    .clk        (Clock),
    .reset      (reset),
    .active     (active),
    .frame_tick (frame_tick),
    .hsync      (Hsinc),
    .vsync      (Vsinc),
    .visible    (Visible),
    .frame_start(FrameStart)
  );

  always_ff @(posedge Clock) begin
    if (reset) begin
      up_q   <= 1'b0;
      up_d   <= 1'b0;
      down_q <= 1'b0;
      down_d <= 1'b0;
    end else begin
      up_q   <= Up;
      up_d   <= up_q;
      down_q <= Down;
      down_d <= down_q;
    end
  end

  // Simultaneous rising edges cancel each other.
  assign inc = (up_q & ~up_d) & ~(down_q & ~down_d);
  assign dec = (down_q & ~down_d) & ~(up_q & ~up_d);

  assign sel   = sel_e'(Sel);
  assign hit_r = (sel == SEL_R) || (sel == SEL_ALL);
  assign hit_g = (sel == SEL_G) || (sel == SEL_ALL);
  assign hit_b = (sel == SEL_B) || (sel == SEL_ALL);

  always_comb begin
    r_next = r_work;
    g_next = g_work;
    b_next = b_work;
    if (inc) begin
      if (hit_r && (r_work != '1)) r_next = r_work + R_W'(1);
      if (hit_g && (g_work != '1)) g_next = g_work + G_W'(1);
      if (hit_b && (b_work != '1)) b_next = b_work + B_W'(1);
    end else if (dec) begin
      if (hit_r && (r_work != '0)) r_next = r_work - R_W'(1);
      if (hit_g && (g_work != '0)) g_next = g_work - G_W'(1);
      if (hit_b && (b_work != '0)) b_next = b_work - B_W'(1);
    end
  end

  // The display copy samples the working value from before any same-cycle edge.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_work <= R_INIT;
      g_work <= G_INIT;
      b_work <= B_INIT;
      r_disp <= R_INIT;
      g_disp <= G_INIT;
      b_disp <= B_INIT;
    end else begin
      r_work <= r_next;
      g_work <= g_next;
      b_work <= b_next;
      if (frame_tick) begin
        r_disp <= r_work;
        g_disp <= g_work;
        b_disp <= b_work;
      end
    end
  end

  always_comb begin
    r_pix = r_disp;
    g_pix = g_disp;
    b_pix = b_disp;
`ifdef VGA_COLOR_BARS_EN
    if (Barras) begin
      r_pix = bar[2] ? r_disp : '0;
      g_pix = bar[1] ? g_disp : '0;
      b_pix = bar[0] ? b_disp : '0;
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      Rojo  <= '0;
      Verde <= '0;
      Azul  <= '0;
    end else begin
      Rojo  <= active ? r_pix : '0;
      Verde <= active ? g_pix : '0;
      Azul  <= active ? b_pix : '0;
    end
  end

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param on a reduced timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV 2).
// The reference model derives every output from the clock count since reset.
module tb_vga_ctrl_param;

  logic       Clock = 1'b0;
  logic       reset;
  logic       Up, Down;
  logic [1:0] Sel;
  logic [2:0] Rojo, Verde;
  logic [1:0] Azul;
  logic       Hsinc, Vsinc, Visible, FrameStart;
`ifdef VGA_COLOR_BARS_EN
  logic       Barras = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 Clock = ~Clock;

  vga_ctrl_param #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0),
    .R_W(3), .G_W(3), .B_W(2)
  ) dut (
    .Clock(Clock), .reset(reset), .Up(Up), .Down(Down), .Sel(Sel),
`ifdef VGA_COLOR_BARS_EN
    .Barras(Barras),
`endif
    .Rojo(Rojo), .Verde(Verde), .Azul(Azul),
    .Hsinc(Hsinc), .Vsinc(Vsinc), .Visible(Visible), .FrameStart(FrameStart)
  );

  // Reference model: pixel n = cyc/2, h = n mod 14, v = (n/14) mod 7; a frame is 196 clocks.
  int          cyc;
  int          m_h, m_v;
  bit          m_vis;
  int          mw[3];
  int          md[3];
  int          maxv[3] = '{7, 7, 3};
  bit          pend_up, pend_dn, prev_up, prev_dn, ru, rd;
  logic [11:0] exp_vec;
  wire  [11:0] act_vec = {Rojo, Verde, Azul, Hsinc, Vsinc, Visible, FrameStart};

  always @(posedge Clock) begin
    #1;
    if (reset) begin
      cyc     = -1;
      mw      = '{7, 7, 3};
      md      = mw;
      pend_up = 0; pend_dn = 0; prev_up = 0; prev_dn = 0;
      exp_vec = {3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    end else begin
      cyc++;
      m_h   = (cyc / 2) % 14;
      m_v   = (cyc / 28) % 7;
      m_vis = (m_h < 8) && (m_v < 4);
      exp_vec = {m_vis ? 3'(md[0]) : 3'd0, m_vis ? 3'(md[1]) : 3'd0, m_vis ? 2'(md[2]) : 2'd0,
                 !(m_h >= 10 && m_h < 12), !(m_v == 5), m_vis, (cyc % 196) == 1};
      if ((cyc % 196) == 1) md = mw;
      for (int i = 0; i < 3; i++) begin
        if (int'(Sel) == 3 || int'(Sel) == i) begin
          if (pend_up && mw[i] < maxv[i]) mw[i]++;
          if (pend_dn && mw[i] > 0) mw[i]--;
        end
      end
      ru = Up && !prev_up;
      rd = Down && !prev_dn;
      pend_up = ru && !rd;
      pend_dn = rd && !ru;
      prev_up = Up;
      prev_dn = Down;
    end
  end

  task automatic apply_reset();
    @(negedge Clock);
    reset = 1'b1;
    repeat (3) @(negedge Clock);
    reset = 1'b0;
  endtask

  task automatic wait_frame_start(input string name);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clock);
      if (FrameStart === 1'b1) found = 1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL %s_timeout: FrameStart not seen within 400 clocks (required within 400)", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Up = 0; Down = 0; Sel = 2'd0;
    repeat (4) @(negedge Clock);
    compared++;
    if (act_vec !== 12'b000_000_00_1_1_0_0) begin
      mismatched++;
      $display("FAIL reset_state: got %h required %h", act_vec, 12'b000_000_00_1_1_0_0);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (Visible !== 1'b0 || Hsinc !== 1'b1 || Vsinc !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_cycle: got vis=%b hs=%b vs=%b required 0 1 1", Visible, Hsinc, Vsinc);
    end
    @(negedge Clock);
    compared++;
    if ({Visible, Rojo, Verde, Azul} !== {1'b1, 3'd7, 3'd7, 2'd3}) begin
      mismatched++;
      $display("FAIL first_pixel: got vis=%b %0d/%0d/%0d required 1 7/7/3", Visible, Rojo, Verde, Azul);
    end
    compared++;
    if (act_vec !== exp_vec) begin
      mismatched++;
      $display("FAIL first_pixel_model: got %h required %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_sync_timing();
    int hs_run = 0, vs_run = 0, n = 0;
    int hs_last = -1, vs_last = -1, fs_last = -1;
    logic hs_p = Hsinc, vs_p = Vsinc, fs_p = FrameStart;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      n++;
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL sync_model: got %h required %h at cyc %0d", act_vec, exp_vec, cyc);
      end
      if (Hsinc === 1'b0) hs_run++;
      else if (hs_run > 0) begin
        compared++;
        if (hs_run != 4) begin
          mismatched++;
          $display("FAIL hsync_width: got %0d clocks required 4", hs_run);
        end
        hs_run = 0;
      end
      if (Vsinc === 1'b0) vs_run++;
      else if (vs_run > 0) begin
        compared++;
        if (vs_run != 28) begin
          mismatched++;
          $display("FAIL vsync_width: got %0d clocks required 28", vs_run);
        end
        vs_run = 0;
      end
      if (hs_p === 1'b1 && Hsinc === 1'b0) begin
        if (hs_last >= 0) begin
          compared++;
          if (n - hs_last != 28) begin
            mismatched++;
            $display("FAIL hsync_period: got %0d required 28", n - hs_last);
          end
        end
        hs_last = n;
      end
      if (vs_p === 1'b1 && Vsinc === 1'b0) begin
        if (vs_last >= 0) begin
          compared++;
          if (n - vs_last != 196) begin
            mismatched++;
            $display("FAIL vsync_period: got %0d required 196", n - vs_last);
          end
        end
        vs_last = n;
      end
      if (FrameStart === 1'b1) begin
        compared++;
        if (fs_p !== 1'b0) begin
          mismatched++;
          $display("FAIL framestart_width: got 2+ clocks required 1");
        end
        if (fs_last >= 0) begin
          compared++;
          if (n - fs_last != 196) begin
            mismatched++;
            $display("FAIL framestart_period: got %0d required 196", n - fs_last);
          end
        end
        fs_last = n;
      end
      hs_p = Hsinc; vs_p = Vsinc; fs_p = FrameStart;
    end
  endtask

  task automatic test_down_steps();
    bit seen = 0;
    apply_reset();
    Sel = 2'd0;
    wait_frame_start("down_start");
    Down = 1'b1; repeat (2) @(negedge Clock);
    Down = 1'b0; repeat (2) @(negedge Clock);
    Down = 1'b1; repeat (2) @(negedge Clock);
    Down = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL down_model: got %h required %h", act_vec, exp_vec);
      end
      if (FrameStart === 1'b1) seen = 1;
      else if (Visible === 1'b1) begin
        compared++;
        if ({Rojo, Verde, Azul} !== {3'd7, 3'd7, 2'd3}) begin
          mismatched++;
          $display("FAIL down_before_frame: got %0d/%0d/%0d required 7/7/3", Rojo, Verde, Azul);
        end
      end
    end
    @(negedge Clock);
    compared++;
    if ({Visible, Rojo, Verde, Azul} !== {1'b1, 3'd5, 3'd7, 2'd3}) begin
      mismatched++;
      $display("FAIL down_after_frame: got vis=%b %0d/%0d/%0d required 1 5/7/3", Visible, Rojo, Verde, Azul);
    end
  endtask

  task automatic test_up_saturation();
    Sel = 2'd2;
    Up  = 1'b1;
    for (int k = 0; k < 1960; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL sat_model: got %h required %h", act_vec, exp_vec);
      end
      if (Visible === 1'b1) begin
        compared++;
        if (Azul !== 2'd3) begin
          mismatched++;
          $display("FAIL blue_saturate: got %0d required 3", Azul);
        end
      end
    end
    Up = 1'b0;
  endtask

  task automatic test_simultaneous_and_hold();
    apply_reset();
    Sel = 2'd3;
    repeat (5) @(negedge Clock);
    Up = 1'b1; Down = 1'b1;
    repeat (4) @(negedge Clock);
    Up = 1'b0; Down = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL simul_model: got %h required %h", act_vec, exp_vec);
      end
      if (Visible === 1'b1) begin
        compared++;
        if ({Rojo, Verde, Azul} !== {3'd7, 3'd7, 2'd3}) begin
          mismatched++;
          $display("FAIL simul_no_change: got %0d/%0d/%0d required 7/7/3", Rojo, Verde, Azul);
        end
      end
    end
    Down = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL hold_model: got %h required %h", act_vec, exp_vec);
      end
    end
    Down = 1'b0;
    wait_frame_start("hold_frame");
    @(negedge Clock);
    compared++;
    if ({Visible, Rojo, Verde, Azul} !== {1'b1, 3'd6, 3'd6, 2'd2}) begin
      mismatched++;
      $display("FAIL hold_single_step: got vis=%b %0d/%0d/%0d required 1 6/6/2", Visible, Rojo, Verde, Azul);
    end
  endtask

  task automatic test_midline_reset();
    int gap = 0;
    wait_frame_start("midline_start");
    repeat (40) @(negedge Clock);
    reset = 1'b1;
    repeat (3) @(negedge Clock);
    reset = 1'b0;
    @(negedge Clock);
    compared++;
    if ({Visible, Rojo, Verde, Azul, FrameStart} !== {1'b1, 3'd7, 3'd7, 2'd3, 1'b0}) begin
      mismatched++;
      $display("FAIL midline_restart: got vis=%b %0d/%0d/%0d fs=%b required 1 7/7/3 0",
               Visible, Rojo, Verde, Azul, FrameStart);
    end
    @(negedge Clock);
    compared++;
    if (FrameStart !== 1'b1) begin
      mismatched++;
      $display("FAIL midline_first_fs: got %b required 1", FrameStart);
    end
    for (int k = 0; k < 300 && gap == 0; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL midline_model: got %h required %h", act_vec, exp_vec);
      end
      if (FrameStart === 1'b1) gap = k + 1;
    end
    compared++;
    if (gap != 196) begin
      mismatched++;
      $display("FAIL midline_next_fs: got %0d clocks required 196", gap);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      @(negedge Clock);
      compared++;
      if (act_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL random_model: got %h required %h at cyc %0d", act_vec, exp_vec, cyc);
      end
      if ($urandom_range(0, 7) == 0) Up = ~Up;
      if ($urandom_range(0, 7) == 0) Down = ~Down;
      if ($urandom_range(0, 15) == 0) Sel = 2'($urandom_range(0, 3));
    end
    Up = 1'b0; Down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_down_steps();
    test_up_saturation();
    test_simultaneous_and_hold();
    test_midline_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
